// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard interface: hazard inputs gathered from the pipeline
// registers, latch control outputs, and the hazard statistics.
interface hazard_ctrl_if;
  logic [3:0]  if_id_rs;
  logic [3:0]  if_id_rt;
  logic [3:0]  id_ex_rd;
  logic        id_ex_memrd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_we;
  logic        if_id_we;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_we;
  logic        mem_wb_flush;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;
  logic        mem_timeout;

  // Pipeline side: supplies hazard information, consumes latch controls.
  modport master (
    output if_id_rs, if_id_rt, id_ex_rd, id_ex_memrd, ex_branch_taken,
    output mem_req, mem_ready,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_flush,
    input  stall_cycles, flush_count, mem_timeout
  );

  // Hazard unit side.
  modport slave (
    input  if_id_rs, if_id_rt, id_ex_rd, id_ex_memrd, ex_branch_taken,
    input  mem_req, mem_ready,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_flush,
    output stall_cycles, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes,
// data-memory wait freezing with a watchdog, and saturating statistics.
// Priority is memory stall > taken branch > load-use; reset overrides all.
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  // Encoding is fixed so RUN reads as 0 and MEM_WAIT as 1.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [15:0] stall_cycles_reg, stall_cycles_next;
  logic [7:0]  flush_count_reg, flush_count_next;
  logic        mem_timeout_reg, mem_timeout_next;

  logic load_use;
  logic mem_stall;
  logic branch_act;

  logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_flush;

  // Hazard detection; register 0 is hardwired and never a dependency.
  always_comb begin
    load_use  = hz.id_ex_memrd && (hz.id_ex_rd != 4'd0) &&
                ((hz.id_ex_rd == hz.if_id_rs) || (hz.id_ex_rd == hz.if_id_rt));
    mem_stall = hz.mem_req && !hz.mem_ready;
  end

  // Latch controls: prioritised hazard decode, reset forces a full flush.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b1;
    mem_wb_flush = 1'b0;
    branch_act   = 1'b0;
    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to MEM; WB receives a bubble. A taken branch
      // held in the frozen EX stage is acted on once the stall clears.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      branch_act   = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  // Memory-wait FSM next state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (mem_stall) state_next = MEM_WAIT;
      MEM_WAIT: if (hz.mem_ready || !hz.mem_req) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Watchdog and statistics next values, all saturating.
  always_comb begin
    wait_cnt_next     = wait_cnt_reg;
    mem_timeout_next  = mem_timeout_reg;
    stall_cycles_next = stall_cycles_reg;
    flush_count_next  = flush_count_reg;
    if (state_reg == RUN) begin
      wait_cnt_next = 8'd0;
    end else if (mem_stall && (wait_cnt_reg != 8'hFF)) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
    if (mem_stall && (wait_cnt_reg == 8'hFF)) begin
      mem_timeout_next = 1'b1;
    end
    if (!pc_we && (stall_cycles_reg != 16'hFFFF)) begin
      stall_cycles_next = stall_cycles_reg + 16'd1;
    end
    if (branch_act && (flush_count_reg != 8'hFF)) begin
      flush_count_next = flush_count_reg + 8'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      wait_cnt_reg     <= 8'd0;
      stall_cycles_reg <= 16'd0;
      flush_count_reg  <= 8'd0;
      mem_timeout_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      wait_cnt_reg     <= wait_cnt_next;
      stall_cycles_reg <= stall_cycles_next;
      flush_count_reg  <= flush_count_next;
      mem_timeout_reg  <= mem_timeout_next;
    end
  end

  assign hz.pc_we        = pc_we;
  assign hz.if_id_we     = if_id_we;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_we    = ex_mem_we;
  assign hz.mem_wb_flush = mem_wb_flush;
  assign hz.stall_cycles = stall_cycles_reg;
  assign hz.flush_count  = flush_count_reg;
  assign hz.mem_timeout  = mem_timeout_reg;

endmodule
